// File: rtl/neuron_mac_accumulator_if.sv
// rtl/neuron_mac_accumulator_if.sv - pair input and z_value output handshake bundle
// master drives pairs and z_ready; slave is the accumulator.
interface neuron_mac_accumulator_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [DATA_W-1:0] in_weight;
   logic [DATA_W-1:0] bias;
   logic              z_valid;
   logic              z_ready;
   logic [DATA_W-1:0] z_value;
   logic              z_sat;

   modport master (
      output in_valid, in_data, in_weight, bias, z_ready,
      input  in_ready, z_valid, z_value, z_sat
   );

   modport slave (
      input  in_valid, in_data, in_weight, bias, z_ready,
      output in_ready, z_valid, z_value, z_sat
   );
endinterface

// File: rtl/neuron_mac_accumulator.sv
// rtl/neuron_mac_accumulator.sv - serial MAC of N_INPUTS Q4.4 pairs plus bias, saturated to Q4.4
// One SAT cycle rescales the Q8.8 sum; the result is held until z_ready.
module neuron_mac_accumulator #(
   parameter int N_INPUTS = 4,
   parameter int DATA_W   = 8,
   parameter int FRAC     = 4,
   parameter int ACC_W    = 20
) (
   input  logic                      clk,
   input  logic                      rst,
   neuron_mac_accumulator_if.slave   bus
);
   localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);
   localparam logic signed [ACC_W:0] Z_MAX = (ACC_W+1)'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [ACC_W:0] Z_MIN = ~Z_MAX;

   typedef enum logic [1:0] {ACC, SAT, OUT} state_t;

   state_t                   state;
   logic [CNT_W-1:0]         count;
   logic signed [ACC_W-1:0]  acc;
   logic                     in_ready_r;
   logic                     z_valid_r;
   logic                     z_sat_r;
   logic [DATA_W-1:0]        z_value_r;

   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    prod_ext;
   logic signed [ACC_W:0]      bias_ext;
   logic signed [ACC_W:0]      sum_s;
   logic signed [ACC_W:0]      sum_t;
   logic                       accept;

   assign prod     = $signed(bus.in_data) * $signed(bus.in_weight);
   assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
   assign bias_ext = {{(ACC_W+1-DATA_W){bus.bias[DATA_W-1]}}, bus.bias};
   // One extra bit on the sum so the bias add cannot wrap a full-scale accumulator.
   assign sum_s    = {acc[ACC_W-1], acc} + (bias_ext <<< FRAC);
   assign sum_t    = sum_s >>> FRAC;
   assign accept   = (state == ACC) && in_ready_r && bus.in_valid;

   assign bus.in_ready = in_ready_r;
   assign bus.z_valid  = z_valid_r;
   assign bus.z_value  = z_value_r;
   assign bus.z_sat    = z_sat_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ACC;
         count      <= '0;
         acc        <= '0;
         in_ready_r <= 1'b0;
         z_valid_r  <= 1'b0;
         z_sat_r    <= 1'b0;
         z_value_r  <= '0;
      end else begin
         case (state)
            ACC: begin
               in_ready_r <= 1'b1;
               if (accept) begin
                  // First pair loads rather than adds, so no earlier sum can leak in.
                  acc <= (count == '0) ? prod_ext : acc + prod_ext;
                  if (count == LAST) begin
                     count      <= '0;
                     in_ready_r <= 1'b0;
                     state      <= SAT;
                  end else begin
                     count <= count + 1'b1;
                  end
               end
            end
            SAT: begin
               if (sum_t > Z_MAX) begin
                  z_value_r <= {1'b0, {(DATA_W-1){1'b1}}};
                  z_sat_r   <= 1'b1;
               end else if (sum_t < Z_MIN) begin
                  z_value_r <= {1'b1, {(DATA_W-1){1'b0}}};
                  z_sat_r   <= 1'b1;
               end else begin
                  z_value_r <= sum_t[DATA_W-1:0];
                  z_sat_r   <= 1'b0;
               end
               z_valid_r <= 1'b1;
               state     <= OUT;
            end
            OUT: begin
               if (bus.z_ready) begin
                  z_valid_r  <= 1'b0;
                  acc        <= '0;
                  in_ready_r <= 1'b1;
                  state      <= ACC;
               end
            end
            default: begin
               state      <= ACC;
               in_ready_r <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// tb/tb_neuron_mac_accumulator.sv - table, random and sequence checks of neuron_mac_accumulator
// Expected results come from explicit constants or a floor-divide integer model.
module tb_neuron_mac_accumulator;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   neuron_mac_accumulator_if #(.DATA_W(8)) bus ();

   neuron_mac_accumulator #(.N_INPUTS(4), .DATA_W(8), .FRAC(4), .ACC_W(20)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [7:0] d[4];
      logic [7:0] w[4];
      logic [7:0] b;
      logic [7:0] ez;
      logic       es;
   } vec_t;

   vec_t tbl[11];

   function automatic vec_t mk(input logic [7:0] d0, d1, d2, d3, w0, w1, w2, w3, b, ez,
                               input logic es);
      vec_t v;
      v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
      v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
      v.b = b; v.ez = ez; v.es = es;
      return v;
   endfunction

   // Real-valued intent: z = floor((sum(d*w) + bias) in 1/16 steps), clamped to [-128,127].
   function automatic void model(input vec_t v, output logic [7:0] z, output logic s);
      int sum, a, c, q;
      sum = 0;
      for (int i = 0; i < 4; i++) begin
         a = $signed(v.d[i]);
         c = $signed(v.w[i]);
         sum += a * c;
      end
      a = $signed(v.b);
      sum += a * 16;
      q = sum / 16;
      if ((sum % 16 != 0) && (sum < 0)) q = q - 1;
      if (q > 127) begin z = 8'h7F; s = 1'b1; end
      else if (q < -128) begin z = 8'h80; s = 1'b1; end
      else begin z = q[7:0]; s = 1'b0; end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic send_pair(input logic [7:0] d, input logic [7:0] w);
      int n;
      bus.in_valid  = 1'b1;
      bus.in_data   = d;
      bus.in_weight = w;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      bus.bias    = v.b;
      bus.z_ready = 1'b1;
      for (int i = 0; i < 4; i++) send_pair(v.d[i], v.w[i]);
      chk({tag, "_sat_cycle_valid"}, {31'd0, bus.z_valid}, 32'd0);
      @(negedge clk);
      chk({tag, "_z_valid"}, {31'd0, bus.z_valid}, 32'd1);
      chk({tag, "_z_value"}, {24'd0, bus.z_value}, {24'd0, v.ez});
      chk({tag, "_z_sat"}, {31'd0, bus.z_sat}, {31'd0, v.es});
      @(negedge clk);
      chk({tag, "_pulse_end"}, {31'd0, bus.z_valid}, 32'd0);
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.z_ready  = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_reset", {31'd0, bus.in_ready}, 32'd1);
   endtask

   initial begin
      vec_t v;
      logic [7:0] zx;
      logic       sx;
      int         n;

      tbl[0]  = mk(8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h00, 8'h40, 1'b0);
      tbl[1]  = mk(8'h10, 8'h10, 8'h10, 8'h10, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'h08, 8'hC8, 1'b0);
      tbl[2]  = mk(8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0);
      tbl[3]  = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h81, 8'h81, 1'b0);
      tbl[4]  = mk(8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b1);
      tbl[5]  = mk(8'h80, 8'h80, 8'h80, 8'h80, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h80, 8'h80, 1'b1);
      tbl[6]  = mk(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h7F, 1'b1);
      tbl[7]  = mk(8'h20, 8'hF0, 8'h08, 8'h00, 8'h20, 8'h10, 8'h08, 8'h7F, 8'h10, 8'h44, 1'b0);
      tbl[8]  = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h7F, 1'b0);
      tbl[9]  = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h80, 1'b0);
      tbl[10] = mk(8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h7F, 1'b1);

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_weight = '0;
      bus.bias      = '0;
      bus.z_ready   = 1'b1;

      @(negedge clk);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("rst_z_valid", {31'd0, bus.z_valid}, 32'd0);
      chk("rst_z_value", {24'd0, bus.z_value}, 32'd0);
      chk("rst_z_sat", {31'd0, bus.z_sat}, 32'd0);
      do_reset();

      for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

      for (int i = 0; i < 40; i++) begin
         for (int k = 0; k < 4; k++) begin
            v.d[k] = 8'($urandom_range(0, 255));
            v.w[k] = 8'($urandom_range(0, 255));
         end
         v.b = 8'($urandom_range(0, 255));
         model(v, zx, sx);
         v.ez = zx;
         v.es = sx;
         run_vec(v, $sformatf("rnd%0d", i));
      end

      // Backpressure: result held, inputs refused while z_ready is low.
      bus.bias    = 8'h00;
      bus.z_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_pair(8'h10, 8'h10);
      n = 0;
      while (bus.z_valid !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("bp_z_valid", {31'd0, bus.z_valid}, 32'd1);
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h7F;
      bus.in_weight = 8'h7F;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", {31'd0, bus.z_valid}, 32'd1);
         chk("bp_hold_value", {24'd0, bus.z_value}, 32'h40);
         chk("bp_hold_sat", {31'd0, bus.z_sat}, 32'd0);
         chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      end
      bus.in_valid = 1'b0;
      bus.z_ready  = 1'b1;
      @(negedge clk);
      chk("bp_release", {31'd0, bus.z_valid}, 32'd0);
      run_vec(tbl[1], "bp_next");

      // Reset part way through an evaluation discards the partial sum and count.
      bus.bias = 8'h00;
      send_pair(8'h7F, 8'h7F);
      send_pair(8'h7F, 8'h7F);
      rst = 1'b1;
      #1;
      chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      do_reset();
      run_vec(tbl[0], "after_mid_rst");

      // Reset while holding a result drops z_valid without a handshake.
      bus.z_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_pair(8'h10, 8'h10);
      @(negedge clk);
      chk("out_z_valid", {31'd0, bus.z_valid}, 32'd1);
      rst = 1'b1;
      #1;
      chk("out_rst_z_valid", {31'd0, bus.z_valid}, 32'd0);
      chk("out_rst_z_value", {24'd0, bus.z_value}, 32'd0);
      do_reset();
      run_vec(tbl[7], "after_out_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
